// File: rtl/alu_serial_seq.sv
// rtl/alu_serial_seq.sv - bit-serial ALU sequencer, one cell evaluation per clock, LSB first
module alu_serial_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero,
  output logic             resp_carry,
  output logic             resp_overflow
);

  localparam int CW = (WIDTH <= 2) ? 1 : $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  // Operands shift right each RUN cycle so the cell always sees bit 0.
  logic             ai, bi, sum, co, bit_res;
  logic [WIDTH-1:0] shifted, final_res;

  // Single 1-bit ALU cell plus result assembly for the current bit.
  always_comb begin
    ai  = a_q[0] ^ op_q[3];
    bi  = b_q[0] ^ op_q[2];
    sum = ai ^ bi ^ c_q;
    co  = (ai & bi) | (ai & c_q) | (bi & c_q);
    case (op_q[1:0])
      2'b00:   bit_res = ai & bi;
      2'b01:   bit_res = ai | bi;
      2'b10:   bit_res = sum;
      default: bit_res = 1'b0;  // less input is tied low for every bit
    endcase
    shifted   = {bit_res, result_q[WIDTH-1:1]};
    final_res = shifted;
    // SLT: the MSB cell's set output (its raw sum) lands in bit 0.
    if (op_q[1:0] == 2'b11) final_res[0] = sum;
  end

  assign req_ready     = (state_q == IDLE) && !rst;
  assign resp_valid    = (state_q == DONE);
  assign resp_result   = result_q;
  assign resp_zero     = zero_q;
  assign resp_carry    = carry_q;
  assign resp_overflow = ovf_q;

  // Next-state and datapath register updates.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    c_d      = c_q;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          state_d = RUN;
          a_d     = req_a;
          b_d     = req_b;
          op_d    = req_op;
          cnt_d   = '0;
          c_d     = req_op[2];
        end
      end
      RUN: begin
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        c_d      = co;
        cnt_d    = cnt_q + CW'(1);
        result_d = shifted;
        if (cnt_q == LAST) begin
          state_d  = DONE;
          result_d = final_res;
          carry_d  = co;
          ovf_d    = c_q ^ co;
          zero_d   = (final_res == '0);
        end
      end
      DONE: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset discards any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      c_q      <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      c_q      <= c_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

endmodule

// File: tb/tb_alu_serial_seq.sv
// tb/tb_alu_serial_seq.sv - directed table-driven bench for alu_serial_seq at WIDTH=8
module tb_alu_serial_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [3:0]   req_op = '0;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic         resp_valid;
  logic         resp_ready = 1'b0;
  logic [W-1:0] resp_result;
  logic         resp_zero;
  logic         resp_carry;
  logic         resp_overflow;

  int ntests = 0;
  int nfail  = 0;

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_a         (req_a),
    .req_b         (req_b),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_result   (resp_result),
    .resp_zero     (resp_zero),
    .resp_carry    (resp_carry),
    .resp_overflow (resp_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       z;
    logic       c;
    logic       ov;
    logic       chk_flags;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one request; returns response fields and edges from accept to resp_valid.
  task automatic do_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] res, output logic z, output logic c,
                       output logic ov, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("req_ready_wait", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_a     = 8'hAA;  // fields must not be sampled after accept
    req_b     = 8'h55;
    lat = 0;
    while (!resp_valid && lat < 50) begin
      @(posedge clk);
      lat++;
      #1;
    end
    res = resp_result;
    z   = resp_zero;
    c   = resp_carry;
    ov  = resp_overflow;
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  logic [7:0] r, hold_r;
  logic       z, c, ov, hz, hc, hov;
  int         lat;

  initial begin
    vecs[0] = '{"add_7f_01", 4'b0010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{"sub_05_05", 4'b0110, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{"slt_fe_03", 4'b0111, 8'hFE, 8'h03, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{"slt_03_fe", 4'b0111, 8'h03, 8'hFE, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{"slt_80_01", 4'b0111, 8'h80, 8'h01, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{"and_f0_3c", 4'b0000, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{"or_f0_3c",  4'b0001, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{"nor_f0_0f", 4'b1100, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{"add_ff_01", 4'b0010, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[9] = '{"sub_00_01", 4'b0110, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset state
    #12;
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("post_rst_outputs", {24'd0, resp_result} | {31'd0, resp_zero} << 8 |
          {31'd0, resp_carry} << 9 | {31'd0, resp_overflow} << 10, 32'd0);

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, r, z, c, ov, lat);
      check({vecs[i].name, "_latency"}, lat, W);
      check({vecs[i].name, "_result"}, {24'd0, r}, {24'd0, vecs[i].res});
      check({vecs[i].name, "_zero"}, {31'd0, z}, {31'd0, vecs[i].z});
      if (vecs[i].chk_flags) begin
        check({vecs[i].name, "_carry"}, {31'd0, c}, {31'd0, vecs[i].c});
        check({vecs[i].name, "_overflow"}, {31'd0, ov}, {31'd0, vecs[i].ov});
      end
    end

    // Response back-pressure, then back-to-back request
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'b0010; req_a = 8'h7F; req_b = 8'h01;
    @(posedge clk); #1;
    req_op = 4'b0110; req_a = 8'h10; req_b = 8'h03;  // next request, held pending
    lat = 0;
    while (!resp_valid && lat < 50) begin
      @(posedge clk); lat++; #1;
    end
    check("hold_latency", lat, W);
    hold_r = resp_result; hz = resp_zero; hc = resp_carry; hov = resp_overflow;
    check("hold_first_result", {24'd0, hold_r}, 32'h80);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_resp_valid", {31'd0, resp_valid}, 32'd1);
      check("hold_req_ready", {31'd0, req_ready}, 32'd0);
      check("hold_stable", {21'd0, hov, hc, hz, hold_r},
            {21'd0, resp_overflow, resp_carry, resp_zero, resp_result});
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("after_pulse_idle", {30'd0, resp_valid, req_ready}, 32'd1);
    @(posedge clk); #1;  // pending request accepted here
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 50) begin
      @(posedge clk); lat++; #1;
    end
    check("b2b_latency", lat, W);
    check("b2b_result", {24'd0, resp_result}, 32'h0D);
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1; resp_ready = 1'b0;

    // Reset during RUN at cnt=3
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'b0010; req_a = 8'h33; req_b = 8'h44;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("midrst_req_ready", {31'd0, req_ready}, 32'd0);
    check("midrst_outputs", {21'd0, resp_overflow, resp_carry, resp_zero, resp_result}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_release_ready", {31'd0, req_ready}, 32'd1);
    repeat (10) begin
      @(posedge clk); #1;
      check("midrst_no_response", {31'd0, resp_valid}, 32'd0);
    end
    do_op(4'b0010, 8'h01, 8'h01, r, z, c, ov, lat);
    check("post_rst_add_result", {24'd0, r}, 32'h02);
    check("post_rst_add_latency", lat, W);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
